// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: divider FSM state encoding,
// default operand widths and the iteration counter width.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Counter must hold the value DIVIDEND_W itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_divider_if.sv
// Operation/result handshake bundle between the calculator control FSM
// (master) and the sequential divider (slave).
interface seq_divider_if
  import calc_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  check_err;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, check_err
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, check_err
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it
// did not go negative.
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] t;
  logic [DIVISOR_W:0] d_ext;

  // Compare/subtract at DIVISOR_W+1 bits; an already-set MSB of the
  // incoming remainder would overflow the shift, so it forces a subtract.
  always_comb begin
    t       = {rem_in[DIVISOR_W-1:0], bit_in};
    d_ext   = {1'b0, divisor};
    q_bit   = rem_in[DIVISOR_W] | (t >= d_ext);
    rem_out = q_bit ? (t - d_ext) : t;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Optional build macro: SEQ_DIVIDER_SELFCHECK_EN -- when defined, the
// result is re-multiplied on entry to DONE and check_err flags a mismatch.
module seq_divider
  import calc_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                state, state_next;
  logic [DIVISOR_W:0]    pr, pr_next;
  logic [DIVIDEND_W-1:0] shreg, q_next;
  logic [DIVISOR_W-1:0]  dsr;
  logic [CNT_W-1:0]      count;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] quotient_r;
  logic [DIVISOR_W-1:0]  rem_r;
  logic                  dbz_r;
  logic                  fire_in, div_zero, last;

  assign bus.in_ready    = (state == IDLE) & ~rst;
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

  assign fire_in  = bus.in_valid & bus.in_ready;
  assign div_zero = (bus.divisor == '0);
  assign last     = (state == CALC) && (count == CNT_W'(1));
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  assign q_next   = {shreg[DIVIDEND_W-2:0], q_bit};

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (pr),
    .bit_in  (shreg[DIVIDEND_W-1]),
    .divisor (dsr),
    .rem_out (pr_next),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: zero divisor short-circuits straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fire_in) state_next = div_zero ? DONE : CALC;
      CALC:    if (count == CNT_W'(1)) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand load, iteration, and result capture on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr         <= '0;
      shreg      <= '0;
      dsr        <= '0;
      count      <= '0;
      quotient_r <= '0;
      rem_r      <= '0;
      dbz_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire_in) begin
          dsr <= bus.divisor;
          if (div_zero) begin
            quotient_r <= '1;
            rem_r      <= bus.dividend[DIVISOR_W-1:0];
            dbz_r      <= 1'b1;
          end else begin
            pr    <= '0;
            shreg <= bus.dividend;
            count <= CNT_W'(DIVIDEND_W);
          end
        end
        CALC: begin
          pr    <= pr_next;
          shreg <= q_next;
          count <= count - CNT_W'(1);
          if (last) begin
            quotient_r <= q_next;
            rem_r      <= pr_next[DIVISOR_W-1:0];
            dbz_r      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  localparam int PW = DIVIDEND_W + DIVISOR_W;

  logic [DIVIDEND_W-1:0] dvd_r;
  logic [PW-1:0]         recon;
  logic                  chk_r;

  // Rebuild the dividend from the result being written this cycle, so the
  // flag lands together with out_valid.
  always_comb begin
    recon = PW'(q_next) * PW'(dsr) + PW'(pr_next[DIVISOR_W-1:0]);
  end

  // Keep the original dividend and register the comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r <= '0;
      chk_r <= 1'b0;
    end else begin
      if (fire_in) dvd_r <= bus.dividend;
      if (fire_in && div_zero) chk_r <= 1'b0;
      else if (last)           chk_r <= (recon != PW'(dvd_r));
    end
  end

  assign bus.check_err = chk_r;
`else
  assign bus.check_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: corner vectors, zero divisor, full
// round trip of the 4x4 product space, backpressure and mid-op reset.
module tb_seq_divider;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seq_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

  seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic pop_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("pop_out_valid", bus.out_valid, 0);
    chk("pop_in_ready", bus.in_ready, 1);
  endtask

  // Issue one operation and wait for its result; latency counts the
  // handshake edge as cycle 1.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edbz, input int elat, input bit pop);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, elat);
    chk("quotient", bus.quotient, eq);
    chk("remainder", bus.remainder, er);
    chk("div_by_zero", bus.div_by_zero, edbz);
    chk("check_err", bus.check_err, 0);
    chk("in_ready_busy", bus.in_ready, 0);
    if (pop) pop_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);
    chk("rst_check_err", bus.check_err, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Directed vectors
    run_op(8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9, 1'b1);
    run_op(8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9, 1'b1);
    run_op(8'd3,   4'd15, 8'd0,   4'd3,  1'b0, 9, 1'b1);
    run_op(8'd0,   4'd5,  8'd0,   4'd0,  1'b0, 9, 1'b1);
    run_op(8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9, 1'b1);
    run_op(8'd5,   4'd0,  8'd255, 4'd5,  1'b1, 1, 1'b1);
    run_op(8'hAB,  4'd0,  8'd255, 4'd11, 1'b1, 1, 1'b1);
    run_op(8'd100, 4'd9,  8'd11,  4'd1,  1'b0, 9, 1'b1);

    // Round trip over every 4x4 product
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        logic [7:0] p;
        p = 8'(a * b);
        run_op(p, 4'(b), 8'(a), 4'd0, 1'b0, 9, 1'b1);
      end
    end

    // Backpressure: hold DONE with a competing request present
    run_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 1'b0);
    bus.dividend = 8'd9;
    bus.divisor  = 4'd2;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_quotient", bus.quotient, 28);
      chk("bp_remainder", bus.remainder, 4);
    end
    bus.in_valid = 1'b0;
    pop_result();
    chk("hold_quotient", bus.quotient, 28);
    chk("hold_remainder", bus.remainder, 4);
    run_op(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 9, 1'b1);

    // Reset during the fourth CALC cycle
    bus.dividend = 8'd250;
    bus.divisor  = 4'd3;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready_low", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_quotient", bus.quotient, 0);
    chk("midrst_remainder", bus.remainder, 0);
    chk("midrst_dbz", bus.div_by_zero, 0);
    run_op(8'd100, 4'd9, 8'd11, 4'd1, 1'b0, 9, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
